// File: rtl/mux_scan_pkg.sv
`default_nettype none
// =============================================================================
// mux_scan_pkg : shared types and sizes for the 4:1 mux scan sequencer
// Revision     : 1.0
// =============================================================================
package mux_scan_pkg;
   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } scan_state_t;
endpackage
`default_nettype wire

// File: rtl/mux_scan_next_ch.sv
`default_nettype none
// =============================================================================
// mux_scan_next_ch : finds the next enabled channel above ch and the lowest one
// Revision         : 1.0
// =============================================================================
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask_q,
   input  logic [SEL_W-1:0]  ch,
   output logic [SEL_W-1:0]  next_ch,
   output logic              found,
   output logic [SEL_W-1:0]  first_ch
);

   // Descending walk so the lowest qualifying channel is the last one written.
   always_comb begin
      next_ch  = '0;
      found    = 1'b0;
      first_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            first_ch = SEL_W'(i);
            if (i > int'(ch)) begin
               next_ch = SEL_W'(i);
               found   = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// =============================================================================
// mux_scan_ctrl : scans a 4:1 mux, samples y per channel after a dwell, and
//                 delivers the 4-bit word over a valid/ready handshake
// Revision      : 1.0
// =============================================================================
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NUM_CH-1:0] mask,
   input  logic              y,
   output logic              s1,
   output logic              s0,
   output logic [NUM_CH-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
);

   localparam logic [7:0] c_dwell_m1 = 8'(DWELL - 1);

   scan_state_t       r_state;
   scan_state_t       w_state_nxt;
   logic [SEL_W-1:0]  r_ch;
   logic [7:0]        r_cnt;
   logic [NUM_CH-1:0] r_mask;
   logic [NUM_CH-1:0] r_data;

   logic [NUM_CH-1:0] w_scan_mask;
   logic [SEL_W-1:0]  w_next_ch;
   logic [SEL_W-1:0]  w_first_ch;
   logic              w_found;
   logic              w_accept;
   logic              w_last;

   assign w_accept    = (r_state == IDLE) && start;
   assign w_last      = (r_cnt == 8'd0);
   // While idle the live mask picks the first channel; afterwards the captured one rules.
   assign w_scan_mask = (r_state == IDLE) ? mask : r_mask;

   mux_scan_next_ch u_next_ch (
      .mask_q   (w_scan_mask),
      .ch       (r_ch),
      .next_ch  (w_next_ch),
      .found    (w_found),
      .first_ch (w_first_ch)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SETTLE;
         SETTLE:  if (w_last && !w_found) w_state_nxt = HOLD;
         HOLD:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // An empty mask still spends one SETTLE cycle on channel 0, sampled as 0,
   // so out_valid lands one edge after acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch   <= '0;
         r_cnt  <= '0;
         r_mask <= '0;
         r_data <= '0;
      end else if (w_accept) begin
         r_mask <= mask;
         r_data <= '0;
         r_ch   <= w_first_ch;
         r_cnt  <= (mask == '0) ? 8'd0 : c_dwell_m1;
      end else if (r_state == SETTLE) begin
         if (w_last) begin
            r_data[r_ch] <= y & r_mask[r_ch];
            if (w_found) begin
               r_ch  <= w_next_ch;
               r_cnt <= c_dwell_m1;
            end
         end else begin
            r_cnt <= r_cnt - 8'd1;
         end
      end
   end

   always_comb begin
      s1        = 1'b0;
      s0        = 1'b0;
      out_data  = '0;
      busy      = (r_state != IDLE);
      out_valid = (r_state == HOLD);
      if (r_state != IDLE) {s1, s0} = r_ch;
      if (r_state == HOLD) out_data = r_data;
   end

endmodule
`default_nettype wire
